// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage : instruction-fetch stage of the five-stage pipeline.
//
// Owns the PC, drives it to the external PC+4 adder and to the instruction
// memory request/ready port, and loads the IF/ID pipeline register. Handles
// hazard-unit stalls and branch/jump redirects (flush of IF/ID).
//
// Optional build macro:
//   IF_PERF_CNT_EN - adds perf_fetch_cnt / perf_bubble_cnt counter outputs.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_plus4_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // BOOT and FLUSH are both single no-request cycles; FETCH is the working state
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  // Next-state and IF/ID update, priority redirect > stall > ready > bubble
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          // A response in this cycle closes the transaction, so the new address
          // may be presented immediately; otherwise drop req for one cycle.
          state_d = imem_ready ? FETCH : FLUSH;
        end else if (stall) begin
          state_d = FETCH;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4_in;
          valid_d = 1'b1;
          pc_d    = pc_plus4_in & ALIGN_MASK;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: begin
        // BOOT / FLUSH: no transaction in flight, IF/ID carries a bubble
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        state_d = FETCH;
      end
    endcase
  end

  // State, PC and IF/ID registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & ALIGN_MASK;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  // Request follows the stall input combinationally so a stall never leaves
  // a transaction outstanding; reset forces BOOT and drops req at once.
  assign imem_req    = (state_q == FETCH) && !stall;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;

`ifdef IF_PERF_CNT_EN
  logic        fetch_evt;
  logic        bubble_evt;
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  assign fetch_evt  = (state_q == FETCH) && !redirect && !stall && imem_ready;
  assign bubble_evt = (state_q == FETCH) && !redirect && !stall && !imem_ready;

  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (fetch_evt) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bubble_evt) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage : self-checking bench for if_fetch_stage.
// Directed scenarios followed by randomized stimulus, all compared each cycle
// against a behavioural model of the fetch stage. Counter checks are active
// when IF_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [31:0] rdata_r = '0;
  logic        use_addr = 1'b1;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  // Model state: PC, IF/ID contents, and whether the stage owes a no-request cycle
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic        m_valid, m_idle;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // External PC+4 adder and memory returning either the address or random data
  assign pc_plus4_in = pc_out + 32'd4;
  assign imem_rdata  = use_addr ? imem_addr : rdata_r;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_out     (pc_out),
    .pc_plus4_in(pc_plus4_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = NOP;
    m_pc4   = '0;
    m_valid = 1'b0;
    m_idle  = 1'b1;
    m_fc    = '0;
    m_bc    = '0;
  endtask

  // One clock of the fetch-stage rules, evaluated with the inputs at the edge
  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] data;
    tgt  = {redirect_pc[31:2], 2'b00};
    data = use_addr ? m_pc : rdata_r;
    if (m_idle) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (redirect) m_pc = tgt;
      m_idle = 1'b0;
    end else if (redirect) begin
      m_pc    = tgt;
      m_valid = 1'b0;
      m_instr = NOP;
      m_idle  = !imem_ready;
    end else if (stall) begin
      m_idle = 1'b0;
    end else if (imem_ready) begin
      m_instr = data;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fc    = m_fc + 32'd1;
    end else begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_bc    = m_bc + 32'd1;
    end
  endtask

  task automatic check_all();
    check_eq("imem_req",    {31'b0, imem_req},    {31'b0, (!m_idle && !stall && rst_n)});
    check_eq("imem_addr",   imem_addr,            m_pc);
    check_eq("pc_out",      pc_out,               m_pc);
    check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check_eq("if_id_instr", if_id_instr,          m_instr);
    check_eq("if_id_pc4",   if_id_pc4,            m_pc4);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch_cnt",  perf_fetch_cnt,  m_fc);
    check_eq("perf_bubble_cnt", perf_bubble_cnt, m_bc);
`endif
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    cycle();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    cycle();
    cycle();
    rst_n = 1'b1;

    // Boot cycle then zero-wait streaming of 0,4,8,C
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("stream_pc", pc_out, 32'h10);
    check_eq("stream_instr", if_id_instr, 32'h0C);
    check_eq("stream_pc4", if_id_pc4, 32'h10);

    // Two wait cycles at 0x10, then the response
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check_eq("wait_addr_held", imem_addr, 32'h10);
    check_eq("wait_instr_nop", if_id_instr, NOP);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch_4", perf_fetch_cnt, 32'd4);
    check_eq("perf_bubble_2", perf_bubble_cnt, 32'd2);
`endif
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("wait_done_pc", pc_out, 32'h14);
    for (int unsigned i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1);

    // Stall for three cycles at 0x20, then resume
    for (int unsigned i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b1);
    check_eq("stall_pc_held", pc_out, 32'h20);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("resume_instr", if_id_instr, 32'h20);

    // Redirect while pending and not ready: one flush cycle, then fetch 0x100
    drive(1'b0, 1'b1, 32'h103, 1'b0);
    check_eq("redir_pc", pc_out, 32'h100);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("redir_fetch", if_id_instr, 32'h100);

    // Redirect with ready in the same cycle: no flush cycle
    drive(1'b0, 1'b1, 32'h207, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("redir_ready_fetch", if_id_instr, 32'h204);
    // Redirect overriding stall
    drive(1'b1, 1'b1, 32'h300, 1'b1);
    check_eq("redir_stall_pc", pc_out, 32'h300);
    drive(1'b0, 1'b0, '0, 1'b1);

    // PC wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("wrap_pc", pc_out, 32'h0);
    check_eq("wrap_pc4", if_id_pc4, 32'h0);

    // Asynchronous reset in the middle of a wait
    drive(1'b0, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check_eq("post_reset_fetch", if_id_instr, RST_PC);

    // Randomized traffic
    use_addr = 1'b0;
    for (int unsigned i = 0; i < 400; i++) begin
      rdata_r = $urandom;
      drive(($urandom_range(3) == 0), ($urandom_range(9) == 0), $urandom,
            ($urandom_range(9) < 6));
    end
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
